// File: rtl/elm_pkg.sv
// Shared types and helpers for the hidden-layer accumulator path.
// No logic of its own; latency and backpressure are defined by the users.
// Holds the sequencer state enum, width defaults and the overflow detect.
package elm_pkg;

    localparam int ACC_W_DEF  = 32;
    localparam int TERM_W_DEF = 32;

    typedef enum logic [1:0] {
        CLR    = 2'd0,
        ACCUM  = 2'd1,
        SETTLE = 2'd2,
        RESULT = 2'd3
    } acc_seq_state_t;

    // Two's-complement add overflows when both operands share a sign that the sum lacks.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/elm_term_counter.sv
// Counts accepted product terms with a synchronous clear and last-term flag.
// Count updates one cycle after inc; last is combinational from the count.
// No backpressure; clear wins over increment.
module elm_term_counter #(
    parameter int N_TERMS = 16,
    parameter int CNT_W   = $clog2(N_TERMS) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign last = (cnt == CNT_W'(N_TERMS - 1));

endmodule

// File: rtl/elm_acc_sequencer.sv
// Drives an external load/clear accumulator through one N_TERMS dot product.
// Result valid N_TERMS+1 cycles after the first accepted term; N_TERMS+3 cycles per product.
// Terms stall while term_ready=0; the result holds until res_ready.
module elm_acc_sequencer
    import elm_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEF,
    parameter int TERM_W  = TERM_W_DEF,
    parameter int N_TERMS = 16,
    parameter int CNT_W   = $clog2(N_TERMS) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TERM_W-1:0] term_in,
    input  logic              term_valid,
    output logic              term_ready,
    input  logic              abort,
    input  logic [ACC_W-1:0]  acc_q,
    output logic [ACC_W-1:0]  acc_data,
    output logic              acc_load,
    output logic              acc_clr,
    output logic [ACC_W-1:0]  res_data,
    output logic              res_ovf,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CNT_W-1:0]  term_cnt
);

    acc_seq_state_t state, state_nxt;
    logic             ovf_q;
    logic             cnt_last;
    logic             cnt_clr;
    logic [ACC_W-1:0] term_ext;

    assign term_ext = ACC_W'(signed'(term_in));
    assign acc_data = acc_q + term_ext;
    assign acc_load = term_valid & term_ready;

    // Clearing on the way into CLR makes an abort visible as term_cnt=0 immediately.
    assign cnt_clr = (state == CLR) || (state_nxt == CLR);

    elm_term_counter #(
        .N_TERMS (N_TERMS),
        .CNT_W   (CNT_W)
    ) u_term_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (acc_load),
        .cnt  (term_cnt),
        .last (cnt_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= CLR;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else if (cnt_clr) begin
            ovf_q <= 1'b0;
        end else if (acc_load && add_ovf(acc_q[ACC_W-1], term_ext[ACC_W-1], acc_data[ACC_W-1])) begin
            ovf_q <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLR:    state_nxt = ACCUM;
            ACCUM:  if (acc_load && cnt_last) state_nxt = SETTLE;
            SETTLE: state_nxt = RESULT;
            RESULT: if (res_ready) state_nxt = CLR;
            default: state_nxt = CLR;
        endcase
        if (abort) begin
            state_nxt = CLR;
        end
    end

    // The register is never loaded in RESULT, so acc_q alone keeps res_data stable.
    always_comb begin
        term_ready = 1'b0;
        acc_clr    = 1'b0;
        res_valid  = 1'b0;
        res_data   = '0;
        res_ovf    = 1'b0;
        case (state)
            CLR:    acc_clr = 1'b1;
            ACCUM:  term_ready = 1'b1;
            RESULT: begin
                res_valid = 1'b1;
                res_data  = acc_q;
                res_ovf   = ovf_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_elm_acc_sequencer.sv
// Randomized bench for elm_acc_sequencer with a behavioural dot-product model.
module tb_elm_acc_sequencer;

    localparam int N     = 4;
    localparam int CNT_W = $clog2(N) + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] term_in = '0;
    logic        term_valid = 1'b0;
    logic        term_ready;
    logic        abort = 1'b0;
    logic [31:0] acc_q;
    logic [31:0] acc_data;
    logic        acc_load;
    logic        acc_clr;
    logic [31:0] res_data;
    logic        res_ovf;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [CNT_W-1:0] term_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] tv [N];
    logic [31:0] acc_reg;

    elm_acc_sequencer #(.ACC_W(32), .TERM_W(32), .N_TERMS(N), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .term_in(term_in), .term_valid(term_valid),
        .term_ready(term_ready), .abort(abort), .acc_q(acc_q), .acc_data(acc_data),
        .acc_load(acc_load), .acc_clr(acc_clr), .res_data(res_data), .res_ovf(res_ovf),
        .res_valid(res_valid), .res_ready(res_ready), .term_cnt(term_cnt)
    );

    always #5 clk = ~clk;

    // External accumulator register: clear beats load, both captured at the edge.
    always @(posedge clk) begin
        if (acc_clr) acc_reg <= '0;
        else if (acc_load) acc_reg <= acc_data;
    end
    assign acc_q = acc_reg;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        term_valid = 1'b1;
        term_in    = 32'd7;
        repeat (2) @(negedge clk);
        n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
        n_chk++; if (term_ready !== 1'b0) begin n_fail++; $display("FAIL reset_term_ready got %b want 0", term_ready); end
        n_chk++; if (acc_clr !== 1'b1) begin n_fail++; $display("FAIL reset_acc_clr got %b want 1", acc_clr); end
        n_chk++; if (acc_load !== 1'b0) begin n_fail++; $display("FAIL reset_acc_load got %b want 0", acc_load); end
        n_chk++; if (term_cnt !== '0) begin n_fail++; $display("FAIL reset_term_cnt got %0d want 0", term_cnt); end
        n_chk++; if (res_data !== 32'd0 || res_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_res got %h/%b want 0/0", res_data, res_ovf); end
        term_valid = 1'b0;
        rst = 1'b1;
    endtask

    // gaps: 0 none, 1 random, 2 alternate cycles; stall: cycles res_ready stays low.
    task automatic do_product(input string name, input int gaps, input int stall);
        logic signed [31:0] s, t32;
        longint w;
        bit o;
        int i, cyc;
        s = 0;
        o = 0;
        for (int k = 0; k < N; k++) begin
            w   = longint'(s) + longint'(signed'(tv[k]));
            t32 = w[31:0];
            if (longint'(t32) != w) o = 1;
            s = t32;
        end

        res_ready = (stall == 0);
        cyc = 0;
        while (term_ready !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
        n_chk++; if (term_ready !== 1'b1) begin n_fail++; $display("FAIL %s_start term_ready got %b want 1", name, term_ready); end

        i = 0;
        cyc = 0;
        while (i < N && cyc < 100) begin
            n_chk++; if (term_cnt !== CNT_W'(i)) begin n_fail++; $display("FAIL %s_cnt got %0d want %0d", name, term_cnt, i); end
            if ((gaps == 1 && $urandom_range(0, 1) == 1) || (gaps == 2 && cyc % 2 == 1)) begin
                term_valid = 1'b0;
                term_in    = $urandom();
            end else begin
                term_valid = 1'b1;
                term_in    = tv[i];
            end
            if (term_ready === 1'b1 && term_valid) i++;
            @(negedge clk);
            cyc++;
        end
        term_valid = 1'b0;
        n_chk++; if (i != N) begin n_fail++; $display("FAIL %s_accept_timeout got %0d terms want %0d", name, i, N); end

        n_chk++; if (term_ready !== 1'b0 || res_valid !== 1'b0 || term_cnt !== CNT_W'(N)) begin
            n_fail++; $display("FAIL %s_settle rdy/vld/cnt got %b/%b/%0d want 0/0/%0d", name, term_ready, res_valid, term_cnt, N);
        end
        @(negedge clk);
        n_chk++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL %s_latency res_valid got %b want 1", name, res_valid); end

        for (int c = 0; c < stall; c++) begin
            n_chk++; if (res_valid !== 1'b1 || res_data !== s || res_ovf !== o || term_ready !== 1'b0) begin
                n_fail++; $display("FAIL %s_stall%0d vld/data/ovf/rdy got %b/%h/%b/%b want 1/%h/%b/0",
                                   name, c, res_valid, res_data, res_ovf, term_ready, s, o);
            end
            @(negedge clk);
        end
        res_ready = 1'b1;
        n_chk++; if (res_data !== s || res_ovf !== o || term_ready !== 1'b0) begin
            n_fail++; $display("FAIL %s_result data/ovf/rdy got %h/%b/%b want %h/%b/0", name, res_data, res_ovf, term_ready, s, o);
        end
        @(negedge clk);
        n_chk++; if (res_valid !== 1'b0 || acc_clr !== 1'b1 || term_cnt !== '0) begin
            n_fail++; $display("FAIL %s_next_clr vld/clr/cnt got %b/%b/%0d want 0/1/0", name, res_valid, acc_clr, term_cnt);
        end
    endtask

    task automatic test_basic();
        tv = '{32'd1, 32'd2, 32'd3, 32'd4};
        do_product("basic", 0, 0);
    endtask

    task automatic test_negative();
        tv = '{-32'sd5, 32'd3, -32'sd1, 32'd0};
        do_product("negative", 0, 0);
    endtask

    task automatic test_gaps_stall();
        tv = '{32'd9, -32'sd4, 32'd100, 32'd1};
        do_product("gaps_stall", 2, 5);
    endtask

    task automatic test_overflow();
        tv = '{32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0};
        do_product("overflow", 0, 0);
        tv = '{32'd1, 32'd1, 32'd1, 32'd1};
        do_product("after_ovf", 0, 0);
    endtask

    task automatic test_abort();
        int cyc;
        cyc = 0;
        while (term_ready !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
        term_valid = 1'b1;
        term_in = 32'd1; @(negedge clk);
        term_in = 32'd2; @(negedge clk);
        n_chk++; if (term_cnt !== CNT_W'(2)) begin n_fail++; $display("FAIL abort_pre_cnt got %0d want 2", term_cnt); end
        term_in = 32'd100;
        abort   = 1'b1;
        @(negedge clk);
        abort      = 1'b0;
        term_valid = 1'b0;
        n_chk++; if (acc_clr !== 1'b1 || term_cnt !== '0 || term_ready !== 1'b0) begin
            n_fail++; $display("FAIL abort_clr clr/cnt/rdy got %b/%0d/%b want 1/0/0", acc_clr, term_cnt, term_ready);
        end
        tv = '{32'd2, 32'd2, 32'd2, 32'd2};
        do_product("post_abort", 0, 0);
    endtask

    task automatic test_reset_mid();
        int cyc;
        cyc = 0;
        while (term_ready !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
        term_valid = 1'b1;
        term_in = 32'd5; @(negedge clk);
        term_in = 32'd6; @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_chk++; if (res_valid !== 1'b0 || term_ready !== 1'b0 || acc_clr !== 1'b1 || term_cnt !== '0 || acc_load !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid vld/rdy/clr/cnt/load got %b/%b/%b/%0d/%b want 0/0/1/0/0",
                               res_valid, term_ready, acc_clr, term_cnt, acc_load);
        end
        term_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        tv = '{32'd1, 32'd2, 32'd3, 32'd4};
        do_product("post_reset", 0, 0);
    endtask

    task automatic test_random();
        for (int p = 0; p < 10; p++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 2) == 0) tv[k] = $urandom();
                else if ($urandom_range(0, 1) == 0) tv[k] = 32'h7FFF_FFF0 + 32'($urandom_range(0, 31));
                else tv[k] = 32'($urandom_range(0, 40)) - 32'd20;
            end
            do_product($sformatf("random%0d", p), int'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_gaps_stall();
        test_overflow();
        test_abort();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
